// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;
    localparam int DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [DW_DEFAULT-1:0] Q_OVF = '1;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [DW-1:0] y_i,
    output logic [DW-1:0] rem_next_o,
    output logic          qbit_o
);
    logic [DW:0] t;
    logic [DW:0] diff;

    assign t          = {rem_i, bit_i};
    assign diff       = t - {1'b0, y_i};
    assign qbit_o     = (t >= {1'b0, y_i});
    // rem_i < y_i on entry, so the restored or subtracted value always fits in DW bits
    assign rem_next_o = qbit_o ? diff[DW-1:0] : t[DW-1:0];
endmodule

// File: rtl/div_top.sv
// Radix-2 restoring divider, 2*DW / DW -> DW quotient and remainder, start/done handshake.
module div_top
    import div_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2*DW-1:0] p,
    input  logic [DW-1:0]   y,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   q,
    output logic [DW-1:0]   r,
    output logic            ovf
);
    localparam int CW = $clog2(DW);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   rem_q, lo_q, quo_q, y_q;
    logic [DW-1:0]   q_q, r_q;
    logic            ovf_q;

    logic            ovf_req;
    logic [DW-1:0]   rem_next;
    logic            qbit;
    logic [DW-1:0]   quo_next;

    // A high half >= y means the quotient cannot fit in DW bits (also covers y == 0)
    assign ovf_req  = (y == '0) || (p[2*DW-1:DW] >= y);
    assign quo_next = {quo_q[DW-2:0], qbit};

    div_step #(.DW(DW)) u_step (
        .rem_i      (rem_q),
        .bit_i      (lo_q[DW-1]),
        .y_i        (y_q),
        .rem_next_o (rem_next),
        .qbit_o     (qbit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ovf_req ? DONE : RUN;
            RUN:     if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN) || (state_q == DONE);
        done = (state_q == DONE);
    end

    // The high half seeds the partial remainder; the low half is shifted in MSB first
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rem_q <= '0;
            lo_q  <= '0;
            quo_q <= '0;
            y_q   <= '0;
            q_q   <= '0;
            r_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    y_q   <= y;
                    lo_q  <= p[DW-1:0];
                    rem_q <= p[2*DW-1:DW];
                    quo_q <= '0;
                    cnt_q <= CW'(DW-1);
                    if (ovf_req) begin
                        q_q   <= '1;
                        r_q   <= '0;
                        ovf_q <= 1'b1;
                    end
                end
                RUN: begin
                    rem_q <= rem_next;
                    lo_q  <= {lo_q[DW-2:0], 1'b0};
                    quo_q <= quo_next;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        q_q   <= quo_next;
                        r_q   <= rem_next;
                        ovf_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q   = q_q;
    assign r   = r_q;
    assign ovf = ovf_q;
endmodule
